bram_port_arbiter: RTL
======================

Name: bram_port_arbiter

Overview:
Round-robin arbiter that shares port A of the 16x8 dual-port BRAM between NUM_REQ requesters. Each requester has a valid/ready command interface (read or write) and a one-hot-tagged read response. The block registers the winning command onto the BRAM port and routes the BRAM's registered read data back to the originating requester. An optional lock input lets one requester hold the port for a bounded burst.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 4, BRAM address width
DATA_WIDTH, 8, BRAM data width
MAX_BURST, 4, max consecutive accepts for a locking requester (1..15)

Ports:
i_CLK  in  1  clock, all logic on rising edge
i_RST_N  in  1  synchronous active-low reset
i_REQ_VALID  in  NUM_REQ  per-requester command valid
i_REQ_WRITE  in  NUM_REQ  1=write, 0=read
i_REQ_LOCK  in  NUM_REQ  request burst ownership
i_REQ_ADDR  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
i_REQ_WDATA  in  NUM_REQ*DATA_WIDTH  packed write data
o_REQ_READY  out  NUM_REQ  one-hot accept
o_RSP_VALID  out  NUM_REQ  one-hot read-response valid
o_RSP_DATA  out  DATA_WIDTH  read data, shared by all requesters
o_READ_ENABLE_A  out  1  to BRAM
o_READ_ADDRESS_A  out  ADDR_WIDTH  to BRAM
o_WRITE_ENABLE_A  out  1  to BRAM
o_WRITE_ADDRESS_A  out  ADDR_WIDTH  to BRAM
o_WRITE_DATA_A  out  DATA_WIDTH  to BRAM
i_READ_DATA_A  in  DATA_WIDTH  from BRAM; registered, valid 1 cycle after the read-enable edge

Behaviour:
- Reset (i_RST_N=0 at an edge):
  - All BRAM-side outputs, o_RSP_VALID and o_RSP_DATA go to 0.
  - Round-robin pointer resets to 0 (requester 0 highest priority); FSM resets to ARB; burst counter resets to 0.
  - In-flight reads are discarded with no response. o_REQ_READY is 0 while i_RST_N=0.
- Handshake:
  - o_REQ_READY is combinational and one-hot; at most one accept per cycle.
  - Accept = i_REQ_VALID[k] & o_REQ_READY[k].
  - No ready when no valid. Ready never depends on the same requester's i_REQ_WRITE.
- FSM state ARB:
  - Winner is the first valid requester scanning from the pointer upward with wrap (pointer, pointer+1, ... NUM_REQ-1, 0, ...).
  - On accept, pointer <= winner+1 mod NUM_REQ.
  - If i_REQ_LOCK[winner]=1 on accept and MAX_BURST>1: go to LOCKED, owner <= winner, burst count <= 1.
- FSM state LOCKED:
  - Only the owner can receive ready. On each owner accept, count increments.
  - Return to ARB when count reaches MAX_BURST, or when the owner presents valid=1 with lock=0 (that beat is accepted as the last one).
  - If the owner drops valid, stay in LOCKED: the port idles and other requesters stall.
- Command stage (registered, 1 cycle):
  - On a read accept: next cycle o_READ_ENABLE_A=1 and o_READ_ADDRESS_A=addr.
  - On a write accept: next cycle o_WRITE_ENABLE_A=1 with o_WRITE_ADDRESS_A and o_WRITE_DATA_A set.
  - With no accept, both enables are 0 next cycle; address and data hold their previous value.
- Response stage:
  - A requester tag is pipelined alongside the read.
  - Two cycles after a read accept: o_RSP_VALID = one-hot tag for one cycle, o_RSP_DATA = i_READ_DATA_A registered through.
  - Back-to-back reads give back-to-back responses. No response is generated for writes.
  - The pipeline never stalls; requesters must always accept responses.
- Ordering:
  - Commands reach the BRAM in accept order.
  - A write accepted in cycle N followed by a read of the same address accepted in N+1 returns the new data.
- Throughput: one command per cycle sustained. Read latency is 2 cycles from accept to o_RSP_VALID.
- Reset mid-burst: FSM returns to ARB, pointer returns to 0, no response for pending reads.

Test Plan:
- Reset, then all valid=0 -> o_REQ_READY=0000, all outputs 0 for 5 cycles.
- R0 write addr 4'h7 data 8'h15; next cycle R0 read 4'h7 -> ready=0001 on both beats; o_WRITE_ENABLE_A=1 with 7/15; o_RSP_VALID=0001 and o_RSP_DATA=8'h15 exactly 2 cycles after the read accept.
- All four valid reads held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; response tags follow the same order with 2-cycle lag.
- R2 valid+lock, R1 and R3 valid, MAX_BURST=4 -> R2 gets 4 consecutive readies, then R3, then R1 (pointer=3 after burst).
- R1 locks, then drops valid for 2 cycles -> no ready to anyone for those cycles; R1 reasserts with lock=0 -> accepted and FSM returns to ARB.
- Reads accepted in cycles N and N+1, reset asserted in N+1 -> no o_RSP_VALID in N+2 or N+3; pointer=0 after release.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// Bundle for the arbiter: requester command/response signals, the BRAM port A
// signals, and FSM debug visibility.
interface bram_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            i_REQ_VALID;
    logic [NUM_REQ-1:0]            i_REQ_WRITE;
    logic [NUM_REQ-1:0]            i_REQ_LOCK;
    logic [NUM_REQ*ADDR_WIDTH-1:0] i_REQ_ADDR;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_REQ_WDATA;
    logic [NUM_REQ-1:0]            o_REQ_READY;
    logic [NUM_REQ-1:0]            o_RSP_VALID;
    logic [DATA_WIDTH-1:0]         o_RSP_DATA;
    logic                          o_READ_ENABLE_A;
    logic [ADDR_WIDTH-1:0]         o_READ_ADDRESS_A;
    logic                          o_WRITE_ENABLE_A;
    logic [ADDR_WIDTH-1:0]         o_WRITE_ADDRESS_A;
    logic [DATA_WIDTH-1:0]         o_WRITE_DATA_A;
    logic [DATA_WIDTH-1:0]         i_READ_DATA_A;
    logic                          dbg_state;
    logic [PTR_W-1:0]              dbg_ptr;

    // Handshake: a command moves when i_REQ_VALID[k] and o_REQ_READY[k] are both
    // high at a rising edge; ready is one-hot, never raised without valid, and
    // responses (o_RSP_VALID) have no back-pressure.
    modport slave (
        input  i_REQ_VALID, i_REQ_WRITE, i_REQ_LOCK, i_REQ_ADDR, i_REQ_WDATA, i_READ_DATA_A,
        output o_REQ_READY, o_RSP_VALID, o_RSP_DATA, o_READ_ENABLE_A, o_READ_ADDRESS_A,
               o_WRITE_ENABLE_A, o_WRITE_ADDRESS_A, o_WRITE_DATA_A, dbg_state, dbg_ptr
    );

    modport master (
        output i_REQ_VALID, i_REQ_WRITE, i_REQ_LOCK, i_REQ_ADDR, i_REQ_WDATA, i_READ_DATA_A,
        input  o_REQ_READY, o_RSP_VALID, o_RSP_DATA, o_READ_ENABLE_A, o_READ_ADDRESS_A,
               o_WRITE_ENABLE_A, o_WRITE_ADDRESS_A, o_WRITE_DATA_A, dbg_state, dbg_ptr
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing BRAM port A among NUM_REQ requesters, with an
// optional bounded lock burst and tagged 2-cycle read responses.
module bram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input logic i_CLK,
    input logic i_RST_N,
    bram_port_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

    state_t                 state;
    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       owner;
    logic [3:0]             cnt;

    logic                   found;
    logic [PTR_W-1:0]       win;
    logic [PTR_W-1:0]       sel;
    logic [PTR_W-1:0]       ptr_next;
    logic [NUM_REQ-1:0]     ready;
    logic                   accept;
    logic                   acc_write;
    logic                   acc_lock;
    logic [ADDR_WIDTH-1:0]  acc_addr;
    logic [DATA_WIDTH-1:0]  acc_wdata;

    logic                   rd_en;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic [NUM_REQ-1:0]     tag_q;
    logic [NUM_REQ-1:0]     rsp_valid_q;

    always_comb begin
        found = 1'b0;
        win   = ptr;
        // Scan from the pointer upward with wrap; first valid requester wins.
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && bus.i_REQ_VALID[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end

        sel   = (state == LOCKED) ? owner : win;
        ready = '0;
        if (i_RST_N) begin
            if (state == ARB) begin
                if (found) ready[win] = 1'b1;
            end else if (bus.i_REQ_VALID[owner]) begin
                ready[owner] = 1'b1;
            end
        end

        accept    = |ready;
        acc_write = bus.i_REQ_WRITE[sel];
        acc_lock  = bus.i_REQ_LOCK[sel];
        acc_addr  = bus.i_REQ_ADDR[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
        acc_wdata = bus.i_REQ_WDATA[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        ptr_next  = (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state       <= ARB;
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            tag_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            rd_en       <= accept & ~acc_write;
            wr_en       <= accept & acc_write;
            tag_q       <= (accept && !acc_write) ? ready : '0;
            rsp_valid_q <= tag_q;
            if (accept && !acc_write) rd_addr <= acc_addr;
            if (accept && acc_write) begin
                wr_addr <= acc_addr;
                wr_data <= acc_wdata;
            end

            if (accept) begin
                ptr <= ptr_next;
                case (state)
                    ARB: begin
                        if (acc_lock && MAX_BURST > 1) begin
                            state <= LOCKED;
                            owner <= sel;
                            cnt   <= 4'd1;
                        end
                    end
                    LOCKED: begin
                        // An unlocked owner beat is the final one of the burst.
                        if (int'(cnt) + 1 >= MAX_BURST || !acc_lock) begin
                            state <= ARB;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    default: state <= ARB;
                endcase
            end
        end
    end

    // BRAM data is already registered by the memory; gate it so idle cycles read 0.
    assign bus.o_RSP_DATA        = (|rsp_valid_q) ? bus.i_READ_DATA_A : '0;
    assign bus.o_RSP_VALID       = rsp_valid_q;
    assign bus.o_REQ_READY       = ready;
    assign bus.o_READ_ENABLE_A   = rd_en;
    assign bus.o_READ_ADDRESS_A  = rd_addr;
    assign bus.o_WRITE_ENABLE_A  = wr_en;
    assign bus.o_WRITE_ADDRESS_A = wr_addr;
    assign bus.o_WRITE_DATA_A    = wr_data;
    assign bus.dbg_state         = state;
    assign bus.dbg_ptr           = ptr;
endmodule
